stream_addr_gen: RTL and testbench
==================================

// Module: stream_addr_gen
// PURPOSE
//  Parametrised successor to the LZ4 input byte-address counter. Per accepted input beat, emits the
//  address of the beat's first byte in three forms: relative (block byte count), absolute
//  (head_addr + relative) and history-window index (relative mod 2^WIN_W).
//  Sits between the input byte packer and the LZ4 hash/match stage, under valid/ready handshakes.
//  Adds block framing: start/last, done pulse, window-wrap pulse and sticky overflow.
// PARAMETERS
//  ADDR_W   32  width of relative/absolute address
//  INCR_W   3   width of incr_bytes (beat carries 0..2^INCR_W-1 bytes)
//  MAX_INCR 4   largest legal incr_bytes; larger values clamp to MAX_INCR and set err_incr
//  WIN_W    16  log2 of LZ4 history window (64 KiB)
// PORTS
//  clk        in  1       clock, all logic on rising edge
//  rst        in  1       asynchronous, active-high reset
//  start      in  1       1-cycle pulse: latch head_addr, clear counter, enter RUN
//  head_addr  in  ADDR_W  block base address, sampled only on start
//  in_valid   in  1       beat present
//  in_ready   out 1       beat accepted when in_valid & in_ready
//  incr_bytes in  INCR_W  bytes in this beat (0 legal)
//  in_last    in  1       final beat of block
//  out_valid  out 1       address beat present
//  out_ready  in  1       downstream accepts
//  rel_addr   out ADDR_W  block-relative address of beat's first byte
//  abs_addr   out ADDR_W  head + rel_addr, modulo 2^ADDR_W
//  win_addr   out WIN_W   rel_addr[WIN_W-1:0]
//  out_last   out 1       copy of in_last for this beat
//  win_wrap   out 1       this beat crossed or ended on a window boundary
//  done       out 1       1-cycle pulse after last beat leaves the output
//  ovf        out 1       sticky: relative counter wrapped; cleared by start
//  err_incr   out 1       sticky: incr_bytes > MAX_INCR seen; cleared by start
// BEHAVIOUR
//  Reset: state IDLE, counter=0, head=0, all outputs 0 (in_ready=0, out_valid=0).
//  FSM IDLE->RUN on start; RUN->LAST on accepting an in_last beat; LAST->IDLE when that beat
//   handshakes at output (done=1 that cycle). start in any state -> RUN next cycle: aborts block,
//   drops a pending output (out_valid=0), clears counter/ovf/err_incr, no done pulse.
//  in_ready = (state==RUN) & !start & (!out_valid | out_ready). Low in IDLE and LAST.
//  Latency: 1 cycle from input handshake to out_valid; full throughput (1 beat/clk) with out_ready=1.
//  On accept: output regs <- {counter, head+counter, counter[WIN_W-1:0], in_last}; then
//   counter <= counter + incr_eff, where incr_eff = min(incr_bytes, MAX_INCR), zero-extended to ADDR_W.
//  win_wrap = carry out of bit WIN_W-1 in counter[WIN_W-1:0] + incr_eff, i.e. the next address
//   lands in a new window.
//  incr_bytes=0: output still produced, counter unchanged.
//  Counter wrap past 2^ADDR_W-1: modulo arithmetic continues, ovf set next cycle.
//  Output held stable while out_valid & !out_ready.
// STRUCTURE
//  Package lz4_addr_pkg: state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_LAST=2'd2; default widths.
//  One sub-module: addr_out_reg, a one-entry valid/ready pipeline register (parametrised width)
//   holding {out_last, win_wrap, win_addr, abs_addr, rel_addr}. FSM and counter stay in top.
// TESTING
//  1. start head=0x1000; 4 beats incr=4 (last on 4th), out_ready=1 -> rel 0,4,8,12; abs 0x1000..0x100C;
//     done 1 cycle after 4th out beat.
//  2. out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs stable, no beat lost or duplicated.
//  3. start; counter preloaded by 16383 beats incr=4 (rel 0xFFFC), then incr=4 -> that beat win_wrap=1,
//     next win_addr=0.
//  4. ADDR_W=8: rel 0xFC, incr=4 -> next rel 0x00, ovf=1; new start clears ovf.
//  5. incr=7 with MAX_INCR=4 -> counter advances 4, err_incr=1; incr=0 -> beat emitted, address repeats.
//  6. start asserted while out_valid=1 and RUN -> output dropped, no done; next beat rel=0 with new head;
//     assert rst mid-block -> all outputs 0 immediately.

Source files
------------

// File: rtl/lz4_addr_pkg.sv
// Shared definitions for the LZ4 stream address generator: FSM state codes and default widths.
package lz4_addr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_INCR_W   = 3;
    localparam int DEF_MAX_INCR = 4;
    localparam int DEF_WIN_W    = 16;

endpackage

// File: rtl/stream_addr_gen_if.sv
// Input beat stream (byte counts) and output address stream of the address generator.
interface stream_addr_gen_if
    import lz4_addr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INCR_W = DEF_INCR_W,
    parameter int WIN_W  = DEF_WIN_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [INCR_W-1:0] incr_bytes;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] rel_addr;
    logic [ADDR_W-1:0] abs_addr;
    logic [WIN_W-1:0]  win_addr;
    logic              out_last;
    logic              win_wrap;

    // Producer/consumer side surrounding the generator.
    modport master (
        output in_valid, incr_bytes, in_last, out_ready,
        input  in_ready, out_valid, rel_addr, abs_addr, win_addr, out_last, win_wrap
    );

    // The generator itself.
    modport slave (
        input  in_valid, incr_bytes, in_last, out_ready,
        output in_ready, out_valid, rel_addr, abs_addr, win_addr, out_last, win_wrap
    );

endinterface

// File: rtl/stream_addr_gen_addr_out_reg.sv
// One-entry valid/ready pipeline register; flush discards the held entry.
module addr_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    assign s_ready = !valid_reg || m_ready;
    assign m_valid = valid_reg;
    assign m_data  = data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (s_valid && s_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= s_data;
        end else if (m_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_addr_gen.sv
// Per accepted input beat, emits relative, absolute and history-window addresses of its first byte,
// with block framing (start/last/done), window-wrap flag and sticky overflow / bad-increment flags.
module stream_addr_gen
    import lz4_addr_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INCR_W   = DEF_INCR_W,
    parameter int MAX_INCR = DEF_MAX_INCR,
    parameter int WIN_W    = DEF_WIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    stream_addr_gen_if.slave  bus,
    output logic              done,
    output logic              ovf,
    output logic              err_incr
);

    localparam int DATA_W = 2 + WIN_W + 2 * ADDR_W;
    localparam logic [INCR_W-1:0] MAX_INCR_V = INCR_W'(MAX_INCR);

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] counter_reg;
    logic [ADDR_W-1:0] head_reg;
    logic              ovf_reg;
    logic              err_reg;
    logic              done_reg;

    logic              accept;
    logic              out_fire;
    logic              pipe_ready;
    logic              incr_bad;
    logic [INCR_W-1:0] incr_eff;
    logic [ADDR_W:0]   counter_ext;
    logic [ADDR_W:0]   incr_ext;
    logic [ADDR_W:0]   sum;
    logic              wrap_win;
    logic [DATA_W-1:0] beat_data;
    logic [DATA_W-1:0] out_data;

    assign accept   = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    assign incr_bad    = bus.incr_bytes > MAX_INCR_V;
    assign incr_eff    = incr_bad ? MAX_INCR_V : bus.incr_bytes;
    assign counter_ext = {1'b0, counter_reg};
    assign incr_ext    = (ADDR_W + 1)'(incr_eff);
    assign sum         = counter_ext + incr_ext;
    // Carry into bit WIN_W recovered from the full-width sum: the low WIN_W bits add identically.
    assign wrap_win    = sum[WIN_W] ^ counter_ext[WIN_W] ^ incr_ext[WIN_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_RUN:  if (accept && bus.in_last) state_next = ST_LAST;
                ST_LAST: if (out_fire && bus.out_last) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (state_reg == ST_RUN) && !start && pipe_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_reg <= '0;
            head_reg    <= '0;
            ovf_reg     <= 1'b0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else if (start) begin
            counter_reg <= '0;
            head_reg    <= head_addr;
            ovf_reg     <= 1'b0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_LAST) && out_fire && bus.out_last;
            if (accept) begin
                counter_reg <= sum[ADDR_W-1:0];
                if (sum[ADDR_W]) ovf_reg <= 1'b1;
                if (incr_bad)    err_reg <= 1'b1;
            end
        end
    end

    assign beat_data = {bus.in_last, wrap_win, counter_reg[WIN_W-1:0],
                        head_reg + counter_reg, counter_reg};

    addr_out_reg #(
        .WIDTH (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .flush   (start),
        .s_valid (accept),
        .s_ready (pipe_ready),
        .s_data  (beat_data),
        .m_valid (bus.out_valid),
        .m_ready (bus.out_ready),
        .m_data  (out_data)
    );

    assign {bus.out_last, bus.win_wrap, bus.win_addr, bus.abs_addr, bus.rel_addr} = out_data;

    assign done     = done_reg;
    assign ovf      = ovf_reg;
    assign err_incr = err_reg;

endmodule

// File: tb/tb_stream_addr_gen.sv
// Directed bench: a default-width instance (A) and an 8-bit address instance (B) for overflow.
module tb_stream_addr_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic        a_start = 1'b0;
    logic [31:0] a_head  = '0;
    logic        a_done, a_ovf, a_err;
    logic        b_start = 1'b0;
    logic [7:0]  b_head  = '0;
    logic        b_done, b_ovf, b_err;

    stream_addr_gen_if #(.ADDR_W(32), .INCR_W(3), .WIN_W(16)) a_bus ();
    stream_addr_gen_if #(.ADDR_W(8),  .INCR_W(3), .WIN_W(4))  b_bus ();

    stream_addr_gen #(.ADDR_W(32), .INCR_W(3), .MAX_INCR(4), .WIN_W(16)) u_dut_a (
        .clk (clk), .rst (rst), .start (a_start), .head_addr (a_head),
        .bus (a_bus), .done (a_done), .ovf (a_ovf), .err_incr (a_err)
    );

    stream_addr_gen #(.ADDR_W(8), .INCR_W(3), .MAX_INCR(4), .WIN_W(4)) u_dut_b (
        .clk (clk), .rst (rst), .start (b_start), .head_addr (b_head),
        .bus (b_bus), .done (b_done), .ovf (b_ovf), .err_incr (b_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_bus.in_valid = 0; a_bus.incr_bytes = 0; a_bus.in_last = 0; a_bus.out_ready = 0;
        b_bus.in_valid = 0; b_bus.incr_bytes = 0; b_bus.in_last = 0; b_bus.out_ready = 0;
        step();
        step();
        check("rst_in_ready", 64'(a_bus.in_ready), 0);
        check("rst_out_valid", 64'(a_bus.out_valid), 0);
        check("rst_rel", 64'(a_bus.rel_addr), 0);
        check("rst_flags", 64'({a_done, a_ovf, a_err}), 0);
        rst = 0;
        step();
        check("idle_in_ready", 64'(a_bus.in_ready), 0);

        // 1: four beats of 4 bytes, last on the fourth
        a_start = 1; a_head = 32'h1000;
        step();
        a_start = 0;
        a_bus.out_ready = 1; a_bus.in_valid = 1; a_bus.incr_bytes = 4;
        for (int i = 0; i < 4; i++) begin
            a_bus.in_last = (i == 3);
            step();
            $display("[TB] t1 beat %0d rel=%0h abs=%0h last=%0b", i, a_bus.rel_addr, a_bus.abs_addr, a_bus.out_last);
            check("t1_valid", 64'(a_bus.out_valid), 1);
            check("t1_rel", 64'(a_bus.rel_addr), 64'(4 * i));
            check("t1_abs", 64'(a_bus.abs_addr), 64'(32'h1000 + 4 * i));
            check("t1_last", 64'(a_bus.out_last), 64'(i == 3));
        end
        a_bus.in_valid = 0; a_bus.in_last = 0;
        check("t1_last_state_in_ready", 64'(a_bus.in_ready), 0);
        check("t1_done_early", 64'(a_done), 0);
        step();
        check("t1_done", 64'(a_done), 1);
        check("t1_drained", 64'(a_bus.out_valid), 0);
        step();
        check("t1_done_pulse", 64'(a_done), 0);

        // 2: downstream stall for three cycles
        a_start = 1; a_head = 32'h2000;
        step();
        a_start = 0;
        a_bus.in_valid = 1; a_bus.incr_bytes = 2;
        step();
        check("t2_rel0", 64'(a_bus.rel_addr), 0);
        step();
        check("t2_rel1", 64'(a_bus.rel_addr), 2);
        a_bus.out_ready = 0;
        #1;
        check("t2_stall_in_ready", 64'(a_bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            $display("[TB] t2 stall %0d rel=%0h valid=%0b", i, a_bus.rel_addr, a_bus.out_valid);
            check("t2_hold_valid", 64'(a_bus.out_valid), 1);
            check("t2_hold_rel", 64'(a_bus.rel_addr), 2);
        end
        a_bus.out_ready = 1; a_bus.in_last = 1;
        step();
        check("t2_rel2", 64'(a_bus.rel_addr), 4);
        check("t2_abs2", 64'(a_bus.abs_addr), 32'h2004);
        check("t2_last", 64'(a_bus.out_last), 1);
        a_bus.in_valid = 0; a_bus.in_last = 0;
        step();
        check("t2_done", 64'(a_done), 1);

        // 3: window boundary after 16383 beats of 4
        a_start = 1; a_head = 32'h0;
        step();
        a_start = 0;
        a_bus.in_valid = 1; a_bus.incr_bytes = 4;
        repeat (16383) @(posedge clk);
        #1;
        check("t3_rel_fff8", 64'(a_bus.rel_addr), 32'hFFF8);
        check("t3_no_wrap", 64'(a_bus.win_wrap), 0);
        step();
        $display("[TB] t3 rel=%0h win=%0h wrap=%0b", a_bus.rel_addr, a_bus.win_addr, a_bus.win_wrap);
        check("t3_rel_fffc", 64'(a_bus.rel_addr), 32'hFFFC);
        check("t3_wrap", 64'(a_bus.win_wrap), 1);
        step();
        $display("[TB] t3 rel=%0h win=%0h wrap=%0b", a_bus.rel_addr, a_bus.win_addr, a_bus.win_wrap);
        check("t3_rel_10000", 64'(a_bus.rel_addr), 32'h10000);
        check("t3_win0", 64'(a_bus.win_addr), 0);
        check("t3_wrap_clear", 64'(a_bus.win_wrap), 0);
        check("t3_ovf", 64'(a_ovf), 0);
        a_bus.in_valid = 0;

        // 4: 8-bit counter overflow
        b_bus.out_ready = 1;
        b_start = 1; b_head = 8'h80;
        step();
        b_start = 0;
        b_bus.in_valid = 1; b_bus.incr_bytes = 4;
        repeat (63) @(posedge clk);
        #1;
        check("t4_rel_f8", 64'(b_bus.rel_addr), 8'hF8);
        check("t4_ovf_pre", 64'(b_ovf), 0);
        step();
        $display("[TB] t4 rel=%0h abs=%0h ovf=%0b", b_bus.rel_addr, b_bus.abs_addr, b_ovf);
        check("t4_rel_fc", 64'(b_bus.rel_addr), 8'hFC);
        check("t4_abs", 64'(b_bus.abs_addr), 8'h7C);
        check("t4_win", 64'(b_bus.win_addr), 4'hC);
        check("t4_wrap", 64'(b_bus.win_wrap), 1);
        check("t4_ovf", 64'(b_ovf), 1);
        step();
        $display("[TB] t4 rel=%0h ovf=%0b", b_bus.rel_addr, b_ovf);
        check("t4_rel_00", 64'(b_bus.rel_addr), 0);
        check("t4_ovf_sticky", 64'(b_ovf), 1);
        b_bus.in_valid = 0;
        b_start = 1;
        step();
        b_start = 0;
        check("t4_ovf_cleared", 64'(b_ovf), 0);
        check("t4_flushed", 64'(b_bus.out_valid), 0);

        // 5: clamped and zero increments
        a_start = 1; a_head = 32'h40;
        step();
        a_start = 0;
        a_bus.in_valid = 1; a_bus.incr_bytes = 7;
        step();
        check("t5_rel0", 64'(a_bus.rel_addr), 0);
        check("t5_err", 64'(a_err), 1);
        a_bus.incr_bytes = 0;
        step();
        check("t5_rel_clamped", 64'(a_bus.rel_addr), 4);
        a_bus.incr_bytes = 3;
        step();
        $display("[TB] t5 rel=%0h abs=%0h err=%0b", a_bus.rel_addr, a_bus.abs_addr, a_err);
        check("t5_rel_repeat", 64'(a_bus.rel_addr), 4);
        check("t5_abs_repeat", 64'(a_bus.abs_addr), 32'h44);

        // 6: start aborts a pending output, then async reset mid-block
        a_bus.in_valid = 0; a_bus.out_ready = 0;
        step();
        check("t6_pending", 64'(a_bus.out_valid), 1);
        a_start = 1; a_head = 32'h300;
        step();
        a_start = 0;
        check("t6_dropped", 64'(a_bus.out_valid), 0);
        check("t6_no_done", 64'(a_done), 0);
        check("t6_err_cleared", 64'(a_err), 0);
        a_bus.in_valid = 1; a_bus.incr_bytes = 1; a_bus.out_ready = 1;
        step();
        $display("[TB] t6 rel=%0h abs=%0h", a_bus.rel_addr, a_bus.abs_addr);
        check("t6_rel0", 64'(a_bus.rel_addr), 0);
        check("t6_abs", 64'(a_bus.abs_addr), 32'h300);
        check("t6_no_done2", 64'(a_done), 0);
        step();
        check("t6_rel1", 64'(a_bus.rel_addr), 1);
        #2;
        rst = 1;
        #1;
        check("t6_rst_valid", 64'(a_bus.out_valid), 0);
        check("t6_rst_rel", 64'(a_bus.rel_addr), 0);
        check("t6_rst_abs", 64'(a_bus.abs_addr), 0);
        check("t6_rst_in_ready", 64'(a_bus.in_ready), 0);
        a_bus.in_valid = 0;
        step();
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
